lsu_align_ctrl: RTL

Load/store alignment controller that sits directly upstream of the word-addressed, byte-enabled data RAM. It accepts RV32I load/store requests carrying a byte address and funct3, and drives the RAM's read/write strobes, byte enables, word address and lane-shifted write data. Misaligned halfword/word accesses that cross a word boundary are split into two sequential word accesses. Load data is reassembled and sign- or zero-extended before it returns to the core in a one-cycle response.

---
 rtl/lsu_align_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_align_ctrl.sv
// Load/store alignment controller in front of a word-addressed, byte-enabled
// data RAM. Shifts store data and byte enables into the RAM lanes. Splits
// boundary-crossing halfword/word accesses into two word accesses. Reassembles
// and sign/zero-extends load data into a registered one-cycle response.
module lsu_align_ctrl #(
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state, state_nxt;

  // Request fields captured at the handshake
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] word0_q;
  logic [31:0] word1_q;

  // Incoming-request classification
  logic        in_bad_f3;
  logic        in_misalign;
  logic        in_err;

  // Latched-request derived geometry
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic [3:0]  mask_q;
  logic [7:0]  be_wide;
  logic [3:0]  be0;
  logic [3:0]  be1;
  logic [3:0]  end_pos;
  logic        split;

  // Load reassembly
  logic [31:0] word0_nxt;
  logic [31:0] word1_nxt;
  logic [63:0] raw64;
  logic [31:0] raw;
  logic [31:0] ext;

  // Classify the request presented on the input: illegal codes and, when
  // misalignment is not supported, any access off its natural boundary.
  always_comb begin
    in_bad_f3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                  (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
    in_misalign = !ALLOW_MISALIGN &&
                  (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    in_err      = in_bad_f3 || in_misalign;
  end

  // Size, lane masks and word-crossing detection for the latched request.
  always_comb begin
    off_q = addr_q[1:0];
    case (f3_q[1:0])
      2'b00:   begin size_q = 3'd1; mask_q = 4'b0001; end
      2'b01:   begin size_q = 3'd2; mask_q = 4'b0011; end
      default: begin size_q = 3'd4; mask_q = 4'b1111; end
    endcase
    be_wide = {4'b0000, mask_q} << off_q;
    be0     = be_wide[3:0];
    be1     = mask_q >> (3'd4 - {1'b0, off_q});
    end_pos = {2'b00, off_q} + {1'b0, size_q};
    split   = end_pos > 4'd4;
  end

  // Load result as it will stand once this edge's RAM word is captured.
  always_comb begin
    word0_nxt = (state == ACC0) ? mem_rdata : word0_q;
    word1_nxt = (state == ACC1) ? mem_rdata : word1_q;
    raw64     = {word1_nxt, word0_nxt} >> {off_q, 3'b000};
    raw       = raw64[31:0];
    case (f3_q)
      3'b000:  ext = {{24{raw[7]}}, raw[7:0]};
      3'b100:  ext = {24'h000000, raw[7:0]};
      3'b001:  ext = {{16{raw[15]}}, raw[15:0]};
      3'b101:  ext = {16'h0000, raw[15:0]};
      default: ext = raw;
    endcase
  end

  // Next-state logic and RAM-side strobes, decoded from the current state.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    state_nxt = state;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    case (state)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) state_nxt = in_err ? RESP : ACC0;
      end
      ACC0: begin
        mem_addr  = {2'b00, addr_q[31:2]};
        mem_be    = be0;
        mem_wdata = wdata_q << {off_q, 3'b000};
        mem_write = we_q;
        mem_read  = !we_q;
        state_nxt = split ? ACC1 : RESP;
      end
      ACC1: begin
        mem_addr  = {2'b00, addr_q[31:2] + 30'd1};
        mem_be    = be1;
        mem_wdata = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});
        mem_write = we_q;
        mem_read  = !we_q;
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request capture, load-word capture and registered response.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      word0_q    <= 32'h0000_0000;
      word1_q    <= 32'h0000_0000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        word1_q <= 32'h0000_0000;
      end
      if (state == ACC0 && !we_q) word0_q <= mem_rdata;
      if (state == ACC1 && !we_q) word1_q <= mem_rdata;
      resp_valid <= (state_nxt == RESP);
      // Only a rejected request goes straight from IDLE to RESP.
      resp_err   <= (state == IDLE) && req_valid && in_err;
      resp_rdata <= ((state_nxt == RESP) && (state != IDLE) && !we_q) ? ext
                                                                     : 32'h0000_0000;
    end
  end

endmodule
